// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port and the
// data port, with a registered req/ack handshake, a starvation guard and an access timeout.
module unified_mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_WAIT     = 15,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   localparam int unsigned WAIT_W   = 8;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state;
   logic                owner_dm;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                starved;
   logic                fetch_win;

   // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row
   assign starved   = (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign fetch_win = if_req & (~dm_req | starved);

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_valid   <= 1'b0;
         dm_valid   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         err        <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (fetch_win) begin
                  owner_dm   <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
                  state      <= BUSY;
               end else if (dm_req) begin
                  owner_dm  <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  if (!if_req)
                     starve_cnt <= '0;
                  else if (!starved)
                     starve_cnt <= starve_cnt + 1'b1;
                  state     <= BUSY;
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY: begin
               // A completion on the timeout cycle takes precedence over the abort
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (owner_dm) begin
                     dm_valid <= 1'b1;
                     dm_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
                  state <= RESP;
               end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (owner_dm) begin
                     dm_valid <= 1'b1;
                     dm_rdata <= '0;
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= '0;
                  end
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               wait_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a simple fixed-latency memory responder.
module tb_unified_mem_arbiter;

   logic        CLK = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic        if_valid, dm_valid;
   logic [31:0] if_rdata, dm_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_if, stall_mem, err;

   int          errors = 0;
   int          checks = 0;
   int          ack_lat = 0;
   int          ack_cnt = 0;
   logic [31:0] mem_data = '0;

   always #5 CLK = ~CLK;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   // Memory model: ack in the (ack_lat+1)-th cycle that mem_req is high
   always @(posedge CLK) begin
      if (rst || !mem_req) ack_cnt <= 0;
      else                 ack_cnt <= ack_cnt + 1;
   end
   assign mem_ack   = mem_req && (ack_cnt == ack_lat);
   assign mem_rdata = mem_data;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int hi;
      logic [9:0] exp_fetch;

      rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      step(); step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_stall_if", 32'(stall_if), 32'd0);
      rst = 1'b0;

      // Single fetch, ack in second mem_req cycle
      ack_lat = 1; mem_data = 32'h0050_0093;
      if_req = 1; if_addr = 32'h100;
      #1 chk("t1_stall_if_req", 32'(stall_if), 32'd1);
      step();
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      step();
      chk("t1_mem_req2", 32'(mem_req), 32'd1);
      chk("t1_no_valid", 32'(if_valid), 32'd0);
      chk("t1_stall_busy", 32'(stall_if), 32'd1);
      step();
      chk("t1_if_valid", 32'(if_valid), 32'd1);
      chk("t1_if_rdata", if_rdata, 32'h0050_0093);
      chk("t1_mem_req_low", 32'(mem_req), 32'd0);
      chk("t1_stall_done", 32'(stall_if), 32'd0);
      if_req = 0;
      step();
      chk("t1_valid_pulse", 32'(if_valid), 32'd0);
      chk("t1_rdata_hold", if_rdata, 32'h0050_0093);

      // Simultaneous store and fetch, immediate ack
      ack_lat = 0; mem_data = 32'h1111_1111;
      if_req = 1; if_addr = 32'h104;
      dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("t2_mem_we", 32'(mem_we), 32'd1);
      chk("t2_mem_addr", mem_addr, 32'h2000);
      chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_stall_mem", 32'(stall_mem), 32'd1);
      step();
      chk("t2_dm_valid", 32'(dm_valid), 32'd1);
      chk("t2_dm_rdata", dm_rdata, 32'd0);
      chk("t2_stall_mem_done", 32'(stall_mem), 32'd0);
      chk("t2_if_wait", 32'(if_valid), 32'd0);
      dm_req = 0; dm_we = 0;
      step();
      chk("t2_idle_mem_req", 32'(mem_req), 32'd0);
      step();
      chk("t2_fetch_grant", 32'(mem_req), 32'd1);
      chk("t2_fetch_addr", mem_addr, 32'h104);
      chk("t2_fetch_we", 32'(mem_we), 32'd0);
      step();
      chk("t2_if_valid", 32'(if_valid), 32'd1);
      chk("t2_if_rdata", if_rdata, 32'h1111_1111);
      if_req = 0;
      step();

      // Starvation guard: 4 data grants, 1 fetch, repeating
      mem_data = 32'hCAFE_0000;
      exp_fetch = 10'b10_0001_0000;
      if_req = 1; if_addr = 32'h200;
      dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
      for (int i = 0; i < 10; i++) begin
         n = 0;
         while (!mem_req && n < 8) begin
            step();
            n++;
         end
         chk($sformatf("t3_grant%0d_seen", i), 32'(mem_req), 32'd1);
         chk($sformatf("t3_grant%0d_fetch", i), 32'(mem_addr == 32'h200), 32'(exp_fetch[i]));
         step();
      end
      chk("t3_dm_rdata", dm_rdata, 32'hCAFE_0000);
      if_req = 0; dm_req = 0;
      step(); step();

      // Timeout on a load
      ack_lat = 255;
      dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
      step();
      hi = 0;
      while (mem_req && hi < 40) begin
         hi++;
         step();
      end
      chk("t4_busy_cycles", 32'(hi), 32'd15);
      chk("t4_dm_valid", 32'(dm_valid), 32'd1);
      chk("t4_dm_rdata", dm_rdata, 32'd0);
      chk("t4_err", 32'(err), 32'd1);
      dm_req = 0;
      ack_lat = 0; mem_data = 32'h1234_5678;
      if_req = 1; if_addr = 32'h300;
      step(); step(); step();
      chk("t4_next_valid", 32'(if_valid), 32'd1);
      chk("t4_next_rdata", if_rdata, 32'h1234_5678);
      chk("t4_err_sticky", 32'(err), 32'd1);
      if_req = 0;
      step();

      // Ack on the exact timeout cycle after clearing err with reset
      rst = 1; #1 rst = 0;
      chk("t5_err_cleared", 32'(err), 32'd0);
      ack_lat = 14; mem_data = 32'hA5A5_A5A5;
      dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
      step();
      hi = 0;
      while (mem_req && hi < 40) begin
         hi++;
         step();
      end
      chk("t5_busy_cycles", 32'(hi), 32'd15);
      chk("t5_dm_valid", 32'(dm_valid), 32'd1);
      chk("t5_dm_rdata", dm_rdata, 32'hA5A5_A5A5);
      chk("t5_err", 32'(err), 32'd0);
      dm_req = 0;
      step();

      // Reset in the middle of a busy fetch
      ack_lat = 255;
      if_req = 1; if_addr = 32'h600;
      step();
      chk("t6_busy", 32'(mem_req), 32'd1);
      step();
      rst = 1;
      #1;
      chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
      chk("t6_rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
      step();
      rst = 0;
      chk("t6_after_rst", 32'(mem_req), 32'd0);
      ack_lat = 0; mem_data = 32'h0BAD_F00D;
      step();
      chk("t6_regrant", 32'(mem_req), 32'd1);
      chk("t6_regrant_addr", mem_addr, 32'h600);
      step();
      chk("t6_if_valid", 32'(if_valid), 32'd1);
      chk("t6_if_rdata", if_rdata, 32'h0BAD_F00D);
      if_req = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
